// File: rtl/acc_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : acc_alu_unit
// Brief    : Accumulator execution stage. Single-cycle ALU ops, plus an
//            iterative shift-add multiply when ACC_ALU_MUL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module acc_alu_unit #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic [WIDTH-1:0] acc_out,
    output logic             acc_write,
    output logic             zero,
    output logic             carry
);

    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_AND  = 3'b010;
    localparam logic [2:0] c_OP_OR   = 3'b011;
    localparam logic [2:0] c_OP_SLL  = 3'b100;
    localparam logic [2:0] c_OP_SRL  = 3'b101;
    localparam logic [2:0] c_OP_MUL  = 3'b110;
    localparam logic [2:0] c_OP_LOAD = 3'b111;

    logic [WIDTH-1:0]   r_acc_out;
    logic               r_acc_write;
    logic               r_zero;
    logic               r_carry;

    logic               w_idle;
    logic               w_issue;
    logic               w_single;
    logic [WIDTH-1:0]   w_res;
    logic               w_carry;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH:0]     w_sll;
    logic [WIDTH:0]     w_srl;

    // One guard bit on each shifter catches the last bit shifted out;
    // a zero shift leaves the guard bit clear, giving carry=0.
    assign w_shamt = operand[SHAMT_W-1:0];
    assign w_sum   = {1'b0, acc_in} + {1'b0, operand};
    assign w_diff  = {1'b0, acc_in} - {1'b0, operand};
    assign w_sll   = {1'b0, acc_in} << w_shamt;
    assign w_srl   = {acc_in, 1'b0} >> w_shamt;

    always_comb begin
        w_res    = '0;
        w_carry  = 1'b0;
        w_single = 1'b1;
        case (op)
            c_OP_ADD:  begin w_res = w_sum[WIDTH-1:0];  w_carry = w_sum[WIDTH];  end
            c_OP_SUB:  begin w_res = w_diff[WIDTH-1:0]; w_carry = w_diff[WIDTH]; end
            c_OP_AND:  w_res = acc_in & operand;
            c_OP_OR:   w_res = acc_in | operand;
            c_OP_SLL:  begin w_res = w_sll[WIDTH-1:0];  w_carry = w_sll[WIDTH];  end
            c_OP_SRL:  begin w_res = w_srl[WIDTH:1];    w_carry = w_srl[0];      end
            c_OP_MUL:  w_single = 1'b0;
            c_OP_LOAD: w_res = operand;
            default:   w_single = 1'b0;
        endcase
    end

    assign w_issue = start & w_idle;

`ifdef ACC_ALU_MUL_EN
    localparam logic [1:0]         c_S_IDLE   = 2'd0;
    localparam logic [1:0]         c_S_MUL    = 2'd1;
    localparam logic [1:0]         c_S_DONE   = 2'd2;
    localparam logic [SHAMT_W-1:0] c_CNT_LAST = SHAMT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [SHAMT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_prod;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_mul_last;

    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_mul_last  = (r_state == c_S_MUL) && (r_cnt == c_CNT_LAST);
    assign w_idle      = (r_state == c_S_IDLE);
    assign busy        = (r_state == c_S_MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_S_IDLE;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start && op == c_OP_MUL) begin
                        r_state  <= c_S_MUL;
                        r_cnt    <= '0;
                        r_prod   <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, acc_in};
                        r_mplier <= operand;
                    end
                end
                c_S_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_S_DONE;
                    end
                end
                c_S_DONE: r_state <= c_S_IDLE;
                default:  r_state <= c_S_IDLE;
            endcase
        end
    end
`else
    assign w_idle = 1'b1;
    assign busy   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_out   <= '0;
            r_acc_write <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
        end else begin
            r_acc_write <= 1'b0;
            if (w_issue && w_single) begin
                r_acc_out   <= w_res;
                r_zero      <= (w_res == '0);
                r_carry     <= w_carry;
                r_acc_write <= 1'b1;
            end
`ifdef ACC_ALU_MUL_EN
            // The final partial product is folded in on the same edge that
            // enters DONE, so the write strobe is visible during DONE.
            else if (w_mul_last) begin
                r_acc_out   <= w_prod_next[WIDTH-1:0];
                r_zero      <= (w_prod_next[WIDTH-1:0] == '0);
                r_carry     <= |w_prod_next[2*WIDTH-1:WIDTH];
                r_acc_write <= 1'b1;
            end
`endif
        end
    end

    assign acc_out   = r_acc_out;
    assign acc_write = r_acc_write;
    assign zero      = r_zero;
    assign carry     = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_acc_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_alu_unit
// Brief    : Randomized self-checking bench for acc_alu_unit against an
//            arithmetic reference model (honours ACC_ALU_MUL_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_alu_unit;

`ifdef ACC_ALU_MUL_EN
    localparam bit c_MUL_EN = 1'b1;
`else
    localparam bit c_MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [15:0] acc_in;
    logic [15:0] operand;
    logic        busy;
    logic [15:0] acc_out;
    logic        acc_write;
    logic        zero;
    logic        carry;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_acc;
    logic        exp_zero;
    logic        exp_carry;

    acc_alu_unit #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .acc_in    (acc_in),
        .operand   (operand),
        .busy      (busy),
        .acc_out   (acc_out),
        .acc_write (acc_write),
        .zero      (zero),
        .carry     (carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic on the operation definitions.
    function automatic void model(input logic [2:0] o, input int unsigned a, input int unsigned b,
                                  output int unsigned r, output logic c);
        int unsigned s;
        int unsigned p;
        s = b % 16;
        c = 1'b0;
        case (o)
            3'd0: begin p = a + b; r = p % 65536; c = (p >= 65536); end
            3'd1: begin r = (a + 65536 - b) % 65536; c = (a < b); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin r = (a << s) % 65536; c = (s != 0) && (((a >> (16 - s)) & 1) == 1); end
            3'd5: begin r = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
            3'd6: begin p = a * b; r = p % 65536; c = (p / 65536) != 0; end
            default: r = b;
        endcase
    endfunction

    task automatic check_held(input string tag);
        check({tag, "_acc"},   acc_out, exp_acc);
        check({tag, "_zero"},  zero,    exp_zero);
        check({tag, "_carry"}, carry,   exp_carry);
    endtask

    task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                          input bit pulse_mid);
        int unsigned r;
        logic        c;
        int          cyc;
        int          busy_cnt;
        int          wr_cnt;
        model(o, a, b, r, c);
        @(negedge clk);
        start = 1'b1; op = o; acc_in = a; operand = b;
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); acc_in = 16'($urandom); operand = 16'($urandom);
        if (o == 3'd6 && !c_MUL_EN) begin
            wr_cnt = 0; busy_cnt = 0;
            for (int i = 0; i < 20; i++) begin
                if (acc_write) wr_cnt++;
                if (busy) busy_cnt++;
                @(negedge clk);
            end
            check("nomul_write", wr_cnt, 0);
            check("nomul_busy", busy_cnt, 0);
            check_held("nomul");
            return;
        end
        cyc = 1;
        busy_cnt = 0;
        if (o == 3'd6) begin
            while (!acc_write && cyc < 40) begin
                if (busy) busy_cnt++;
                start = (pulse_mid && cyc == 6);
                if (start) begin
                    op = 3'($urandom); acc_in = 16'($urandom); operand = 16'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
            start = 1'b0;
            check("mul_latency", cyc, 17);
            check("mul_busy_cycles", busy_cnt, 16);
        end
        check("op_busy_at_write", busy, 0);
        check("op_write", acc_write, 1);
        exp_acc = r[15:0]; exp_zero = (r == 0); exp_carry = c;
        check_held("op");
        @(negedge clk);
        check("op_write_pulse", acc_write, 0);
        check_held("op_hold");
    endtask

    initial begin
        logic [2:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        int          wr_cnt;
        int unsigned r;
        logic        c;

        reset = 1'b1; start = 1'b0; op = '0; acc_in = '0; operand = '0;
        exp_acc = '0; exp_zero = 1'b0; exp_carry = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_write", acc_write, 0);
        check_held("rst");
        reset = 1'b0;

        // Directed cases from the defining examples.
        run_op(3'd0, 16'hFFFF, 16'h0001, 1'b0);
        run_op(3'd1, 16'h0003, 16'h0005, 1'b0);
        run_op(3'd1, 16'h0005, 16'h0003, 1'b0);
        run_op(3'd4, 16'h8001, 16'h0001, 1'b0);
        run_op(3'd5, 16'h0001, 16'h0000, 1'b0);
        run_op(3'd6, 16'h0100, 16'h0101, 1'b1);
        run_op(3'd7, 16'h0000, 16'h1234, 1'b0);

        // Reset in the middle of a multiply.
        if (c_MUL_EN) begin
            @(negedge clk);
            start = 1'b1; op = 3'd6; acc_in = 16'h00FF; operand = 16'h0002;
            @(negedge clk);
            start = 1'b0;
            repeat (4) @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            exp_acc = '0; exp_zero = 1'b0; exp_carry = 1'b0;
            check("midrst_busy", busy, 0);
            check("midrst_write", acc_write, 0);
            check_held("midrst");
            wr_cnt = 0;
            for (int i = 0; i < 25; i++) begin
                if (acc_write) wr_cnt++;
                @(negedge clk);
            end
            check("midrst_no_write", wr_cnt, 0);
            run_op(3'd0, 16'h0002, 16'h0003, 1'b0);
        end

        // Back-to-back single-cycle ops, one start per cycle.
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check("b2b_write", acc_write, 1);
                check_held("b2b");
            end
            if (k < 8) begin
                ro = 3'($urandom_range(0, 5));
                ra = 16'($urandom); rb = 16'($urandom);
                model(ro, ra, rb, r, c);
                start = 1'b1; op = ro; acc_in = ra; operand = rb;
                exp_acc = r[15:0]; exp_zero = (r == 0); exp_carry = c;
            end else begin
                start = 1'b0;
            end
        end

        // Random operations, biased toward boundary operand values.
        for (int n = 0; n < 150; n++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: rb = ra;
                default: rb = 16'($urandom);
            endcase
            run_op(ro, ra, rb, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
